lfsr_word_collector: RTL and testbench

Serial-to-parallel collector placed directly downstream of the LFSR/CRC generator. It consumes the generator's serial bit (`OUT`) and its qualifying `Valid` flag, and re-times `Valid` to line up with the registered serial bit. It packs each run of WIDTH qualified bits into a word, LSB first, and holds completed words in a small FIFO behind a ready/valid output handshake. Framing errors and FIFO overflow are flagged to the consumer.

---
 rtl/lfsr_rx_pkg.sv | 13 +
 rtl/lfsr_rx_fifo.sv | 48 ++++
 rtl/lfsr_word_collector.sv | 120 ++++++++++++
 tb/tb_lfsr_word_collector.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/lfsr_rx_pkg.sv
// Shared types and constants for the LFSR serial word collector.
package lfsr_rx_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } rx_state_t;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 2;
    localparam int CNT_W     = 8;

endpackage

// File: rtl/lfsr_rx_fifo.sv
// Small synchronous FIFO; the extra pointer MSB separates full from empty.
module lfsr_rx_fifo
    import lfsr_rx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only safe when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/lfsr_word_collector.sv
// Packs qualified serial bits from the LFSR/CRC generator into LSB-first words,
// queued behind a ready/valid handshake with framing and overflow flags.
module lfsr_word_collector
    import lfsr_rx_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int VALID_DLY = 1,
    parameter int DEPTH     = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_in,
    input  logic             ser_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             overflow,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;

    logic             q_valid;
    rx_state_t        state;
    rx_state_t        state_nxt;
    logic [IDX_W-1:0] bit_idx;
    logic [WIDTH-2:0] shreg;
    logic             sample;
    logic             complete;
    logic             abort;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_head;
    logic             pop;
    logic             wr_en;
    logic [WIDTH-1:0] word;

    // Stage p0..: qualifier delay line aligning ser_valid with the registered serial bit
    if (VALID_DLY == 0) begin : g_no_dly
        assign q_valid = ser_valid;
    end else begin : g_dly
        logic [VALID_DLY-1:0] vld_p;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_p <= '0;
            end else begin
                vld_p[0] <= ser_valid;
                for (int i = 1; i < VALID_DLY; i++) vld_p[i] <= vld_p[i-1];
            end
        end
        assign q_valid = vld_p[VALID_DLY-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (q_valid) state_nxt = COLLECT;
            COLLECT: if (!q_valid || bit_idx == LAST_IDX) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sample   = q_valid;
        complete = 1'b0;
        abort    = 1'b0;
        if (state == COLLECT) begin
            complete = q_valid && (bit_idx == LAST_IDX);
            abort    = !q_valid;
        end
    end

    // The final bit bypasses the shift register straight into the word.
    assign word      = {ser_in, shreg};
    assign out_valid = !fifo_empty;
    assign out_data  = out_valid ? fifo_head : '0;
    assign pop       = out_valid && out_ready;
    assign wr_en     = complete && (!fifo_full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
            word_cnt  <= '0;
        end else begin
            frame_err <= abort;
            if (sample && !complete) shreg[bit_idx] <= ser_in;
            if (complete || abort)   bit_idx <= '0;
            else if (sample)         bit_idx <= bit_idx + IDX_ONE;
            if (wr_en)               word_cnt <= word_cnt + CNT_ONE;
            if (complete && !wr_en)  overflow <= 1'b1;
        end
    end

    lfsr_rx_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (wr_en),
        .wr_data(word),
        .pop    (pop),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .head   (fifo_head)
    );

endmodule

// File: tb/tb_lfsr_word_collector.sv
// Directed bench for lfsr_word_collector at default parameters.
module tb_lfsr_word_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic       ser_in;
    logic       ser_valid;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       frame_err;
    logic       overflow;
    logic [7:0] word_cnt;

    int errors = 0;
    int checks = 0;

    lfsr_word_collector dut (
        .clk      (clk),
        .rst      (rst),
        .ser_in   (ser_in),
        .ser_valid(ser_valid),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .frame_err(frame_err),
        .overflow (overflow),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        ser_in    = 1'b0;
        ser_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Raw valid leads the data by one cycle (VALID_DLY=1); bits go LSB first.
    // pop_at >= 0 pulses out_ready only during that loop cycle.
    task automatic send_bits(input logic [31:0] bits, input int n, input int pop_at);
        for (int i = 0; i <= n; i++) begin
            ser_valid = (i < n);
            ser_in    = (i > 0) ? bits[i-1] : 1'b0;
            if (pop_at >= 0) out_ready = (i == pop_at);
            tick();
        end
        ser_in = 1'b0;
        if (pop_at >= 0) out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ser_in = 1'b0; ser_valid = 1'b0; out_ready = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        checks++; if (word_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", word_cnt); end
        apply_reset();
    endtask

    task automatic test_single_word();
        apply_reset();
        out_ready = 1'b1;
        send_bits(32'hD, 4, -1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
        checks++; if (out_data !== 4'hD) begin errors++; $display("FAIL single_data: got %h want d", out_data); end
        checks++; if (word_cnt !== 8'd1) begin errors++; $display("FAIL single_cnt: got %0d want 1", word_cnt); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_abort();
        apply_reset();
        out_ready = 1'b1;
        send_bits(32'h3, 2, -1);
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL abort_early: got %b want 0", frame_err); end
        tick();
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL abort_pulse: got %b want 1", frame_err); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b want 0", out_valid); end
        tick();
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL abort_pulse_end: got %b want 0", frame_err); end
        checks++; if (word_cnt !== 8'd0) begin errors++; $display("FAIL abort_cnt: got %0d want 0", word_cnt); end
        send_bits(32'hA, 4, -1);
        checks++; if (out_valid !== 1'b1 || out_data !== 4'hA) begin errors++; $display("FAIL abort_next: got v=%b d=%h want v=1 d=a", out_valid, out_data); end
        checks++; if (word_cnt !== 8'd1) begin errors++; $display("FAIL abort_next_cnt: got %0d want 1", word_cnt); end
    endtask

    task automatic test_overflow();
        apply_reset();
        send_bits(32'h5A3, 12, -1);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        checks++; if (word_cnt !== 8'd2) begin errors++; $display("FAIL ovf_cnt: got %0d want 2", word_cnt); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 4'h3) begin errors++; $display("FAIL ovf_head_hold: got v=%b d=%h want v=1 d=3", out_valid, out_data); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 4'hA) begin errors++; $display("FAIL ovf_second: got v=%b d=%h want v=1 d=a", out_valid, out_data); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain: got %b want 0", out_valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_full_pop();
        apply_reset();
        send_bits(32'hFA3, 12, 12);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf: got %b want 0", overflow); end
        checks++; if (word_cnt !== 8'd3) begin errors++; $display("FAIL fullpop_cnt: got %0d want 3", word_cnt); end
        checks++; if (out_valid !== 1'b1 || out_data !== 4'hA) begin errors++; $display("FAIL fullpop_first: got v=%b d=%h want v=1 d=a", out_valid, out_data); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 4'hF) begin errors++; $display("FAIL fullpop_second: got v=%b d=%h want v=1 d=f", out_valid, out_data); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fullpop_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        send_bits(32'h9, 4, -1);
        send_bits(32'h3, 2, -1);
        checks++; if (out_valid !== 1'b1 || out_data !== 4'h9) begin errors++; $display("FAIL midrst_pre: got v=%b d=%h want v=1 d=9", out_valid, out_data); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 4'h0) begin errors++; $display("FAIL midrst_async_out: got v=%b d=%h want v=0 d=0", out_valid, out_data); end
        checks++; if (word_cnt !== 8'd0) begin errors++; $display("FAIL midrst_async_cnt: got %0d want 0", word_cnt); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL midrst_ferr: got %b want 0", frame_err); end
        send_bits(32'h6, 4, -1);
        checks++; if (out_valid !== 1'b1 || out_data !== 4'h6) begin errors++; $display("FAIL midrst_next: got v=%b d=%h want v=1 d=6", out_valid, out_data); end
        checks++; if (word_cnt !== 8'd1) begin errors++; $display("FAIL midrst_cnt: got %0d want 1", word_cnt); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_flushed: got %b want 0", out_valid); end
    endtask

    task automatic test_wrap();
        logic [3:0] v;
        apply_reset();
        out_ready = 1'b1;
        for (int w = 0; w < 256; w++) begin
            v = 4'(w);
            send_bits({28'd0, v}, 4, -1);
            checks++;
            if (out_valid !== 1'b1 || out_data !== v) begin
                errors++;
                $display("FAIL wrap_word%0d: got v=%b d=%h want v=1 d=%h", w, out_valid, out_data, v);
            end
            if (w == 254) begin
                checks++; if (word_cnt !== 8'd255) begin errors++; $display("FAIL wrap_cnt255: got %0d want 255", word_cnt); end
            end
        end
        checks++; if (word_cnt !== 8'd0) begin errors++; $display("FAIL wrap_cnt0: got %0d want 0", word_cnt); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_ovf: got %b want 0", overflow); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_abort();
        test_overflow();
        test_full_pop();
        test_mid_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
